// File: rtl/io_scan_controller_if.sv
// RAM IO-port bundle between the scan controller (master) and the dual-port data RAM (slave).
interface io_scan_controller_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
);
    logic [ADDRESS_WIDTH-1:0] IO_addr;
    logic                     IO_wEn;
    logic [DATA_WIDTH-1:0]    IO_dataIn;
    logic [DATA_WIDTH-1:0]    IO_dataOut;

    modport master (output IO_addr, output IO_wEn, output IO_dataIn, input IO_dataOut);
    modport slave  (input IO_addr, input IO_wEn, input IO_dataIn, output IO_dataOut);
endinterface

// File: rtl/io_scan_controller.sv
// Periodic exchange of the memory-mapped IO window: fetch output slots, then write synchronized inputs.
// Optional IO_SCAN_CHANGE_ONLY_EN: only write input slots whose value differs from the last one written.
module io_scan_controller #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int NUM_SLOTS     = 5,
    parameter int OUT_BASE      = 4091,
    parameter int IN_BASE       = 4086,
    parameter int SCAN_PERIOD   = 1000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            scan_en,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0] in_data,
    io_scan_controller_if.master            ram,
    output logic [NUM_SLOTS*DATA_WIDTH-1:0] out_regs,
    output logic                            busy,
    output logic                            scan_done,
    output logic                            overrun
);
    localparam int CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [CNT_W-1:0]         CNT_LOAD  = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_SLOTS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] OUT_BASE_A = ADDRESS_WIDTH'(OUT_BASE);
    localparam logic [ADDRESS_WIDTH-1:0] IN_BASE_A  = ADDRESS_WIDTH'(IN_BASE);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

    state_t                             state_reg;
    logic [CNT_W-1:0]                   cnt_reg;
    logic                               pending_reg;
    logic [IDX_W-1:0]                   idx_reg;
    logic [NUM_SLOTS*DATA_WIDTH-1:0]    sync1_reg;
    logic [NUM_SLOTS*DATA_WIDTH-1:0]    sync2_reg;
    logic [DATA_WIDTH-1:0]              sync_slot    [NUM_SLOTS];
    logic [DATA_WIDTH-1:0]              snap_reg     [NUM_SLOTS];
    logic [DATA_WIDTH-1:0]              out_slot_reg [NUM_SLOTS];
    logic [ADDRESS_WIDTH-1:0]           io_addr_reg;
    logic                               io_wen_reg;
    logic [DATA_WIDTH-1:0]              io_din_reg;
    logic                               busy_reg;
    logic                               scan_done_reg;
    logic                               overrun_reg;
`ifdef IO_SCAN_CHANGE_ONLY_EN
    logic [DATA_WIDTH-1:0]              last_reg     [NUM_SLOTS];
`endif

    logic                               expire;
    logic                               go;
    logic [IDX_W-1:0]                   wr_next_idx;
    logic [DATA_WIDTH-1:0]              wr_next_val;
    logic                               wen_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign sync_slot[gi]                         = sync2_reg[gi*DATA_WIDTH +: DATA_WIDTH];
            assign out_regs[gi*DATA_WIDTH +: DATA_WIDTH] = out_slot_reg[gi];
        end
    endgenerate

    assign expire = scan_en && (cnt_reg == '0);
    // An expiry seen while idle starts the scan directly, so READ follows the expiry cycle.
    assign go     = (state_reg == IDLE) && (pending_reg || expire);

    // Outputs are registered, so the next WRITE slot is prepared one cycle ahead.
    assign wr_next_idx = (state_reg == WRITE && idx_reg != LAST_IDX) ? idx_reg + IDX_W'(1) : '0;
    assign wr_next_val = (state_reg == DRAIN) ? sync_slot[0] : snap_reg[wr_next_idx];
`ifdef IO_SCAN_CHANGE_ONLY_EN
    assign wen_next = (wr_next_val != last_reg[wr_next_idx]);
`else
    assign wen_next = 1'b1;
`endif

    assign ram.IO_addr   = io_addr_reg;
    assign ram.IO_wEn    = io_wen_reg;
    assign ram.IO_dataIn = io_din_reg;
    assign busy          = busy_reg;
    assign scan_done     = scan_done_reg;
    assign overrun       = overrun_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= in_data;
            sync2_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= CNT_LOAD;
            pending_reg   <= 1'b0;
            idx_reg       <= '0;
            io_addr_reg   <= '0;
            io_wen_reg    <= 1'b0;
            io_din_reg    <= '0;
            busy_reg      <= 1'b0;
            scan_done_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                out_slot_reg[k] <= '0;
                snap_reg[k]     <= '0;
`ifdef IO_SCAN_CHANGE_ONLY_EN
                last_reg[k]     <= '0;
`endif
            end
        end else begin
            scan_done_reg <= 1'b0;
            overrun_reg   <= expire && pending_reg;
            if (scan_en) begin
                cnt_reg <= (cnt_reg == '0) ? CNT_LOAD : cnt_reg - CNT_W'(1);
            end
            // A second expiry before the first is served merges into the same request.
            if (go) begin
                pending_reg <= 1'b0;
            end else if (expire) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    io_wen_reg <= 1'b0;
                    if (go) begin
                        state_reg   <= READ;
                        idx_reg     <= '0;
                        io_addr_reg <= OUT_BASE_A;
                        busy_reg    <= 1'b1;
                    end
                end
                READ: begin
                    // Read data lags the address by one cycle.
                    if (idx_reg != '0) begin
                        out_slot_reg[idx_reg - IDX_W'(1)] <= ram.IO_dataOut;
                    end
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= DRAIN;
                    end else begin
                        idx_reg     <= idx_reg + IDX_W'(1);
                        io_addr_reg <= OUT_BASE_A + ADDRESS_WIDTH'(idx_reg + IDX_W'(1));
                    end
                end
                DRAIN: begin
                    out_slot_reg[LAST_IDX] <= ram.IO_dataOut;
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        snap_reg[k] <= sync_slot[k];
                    end
                    state_reg   <= WRITE;
                    idx_reg     <= '0;
                    io_addr_reg <= IN_BASE_A;
                    io_din_reg  <= wr_next_val;
                    io_wen_reg  <= wen_next;
                end
                WRITE: begin
`ifdef IO_SCAN_CHANGE_ONLY_EN
                    if (io_wen_reg) begin
                        last_reg[idx_reg] <= io_din_reg;
                    end
`endif
                    if (idx_reg == LAST_IDX) begin
                        state_reg     <= IDLE;
                        io_wen_reg    <= 1'b0;
                        busy_reg      <= 1'b0;
                        scan_done_reg <= 1'b1;
                    end else begin
                        idx_reg     <= wr_next_idx;
                        io_addr_reg <= IN_BASE_A + ADDRESS_WIDTH'(wr_next_idx);
                        io_din_reg  <= wr_next_val;
                        io_wen_reg  <= wen_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_scan_controller.sv
// Scoreboard bench: two controllers (period 20 and period 5) each backed by a small RAM model.
module tb_io_scan_controller;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NS = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              scan_en_a, scan_en_b;
    logic [NS*DW-1:0]  in_data_a, in_data_b, out_regs_a, out_regs_b;
    logic              busy_a, done_a, ovr_a, busy_b, done_b, ovr_b;

    io_scan_controller_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_a ();
    io_scan_controller_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_b ();

    io_scan_controller #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_SLOTS(NS),
                         .OUT_BASE(4091), .IN_BASE(4086), .SCAN_PERIOD(20)) dut_a (
        .clk(clk), .reset_n(reset_n), .scan_en(scan_en_a), .in_data(in_data_a), .ram(bus_a),
        .out_regs(out_regs_a), .busy(busy_a), .scan_done(done_a), .overrun(ovr_a));

    io_scan_controller #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_SLOTS(NS),
                         .OUT_BASE(4091), .IN_BASE(4086), .SCAN_PERIOD(5)) dut_b (
        .clk(clk), .reset_n(reset_n), .scan_en(scan_en_b), .in_data(in_data_b), .ram(bus_b),
        .out_regs(out_regs_b), .busy(busy_b), .scan_done(done_b), .overrun(ovr_b));

    // RAM models: IO port with registered read, plus a CPU write port for instance A.
    logic [DW-1:0] ram_a [4096];
    logic [DW-1:0] ram_b [4096];
    logic [DW-1:0] rd_a, rd_b;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;

    always @(posedge clk) begin
        if (cpu_we) ram_a[cpu_addr] <= cpu_data;
        if (bus_a.IO_wEn) ram_a[bus_a.IO_addr] <= bus_a.IO_dataIn;
        else              rd_a <= ram_a[bus_a.IO_addr];
        if (bus_b.IO_wEn) ram_b[bus_b.IO_addr] <= bus_b.IO_dataIn;
        else              rd_b <= ram_b[bus_b.IO_addr];
    end
    assign bus_a.IO_dataOut = rd_a;
    assign bus_b.IO_dataOut = rd_b;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [NS*DW-1:0] act, input logic [NS*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
        else $display("ok   %s = %0h", name, act);
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Scoreboard: expected writes {addr,data} and expected out_regs per scan_done.
    logic [AW+DW-1:0] exp_wr_q  [$];
    logic [NS*DW-1:0] exp_out_q [$];
    logic [DW-1:0]    last_model [NS];
    logic [NS*DW-1:0] out_exp;
    int               wr_cnt_a = 0;

    task automatic push_scan(input logic [NS*DW-1:0] snap, input logic [NS*DW-1:0] outs);
        for (int j = 0; j < NS; j++) begin
            logic [DW-1:0] v;
            logic          do_wr;
            v     = snap[j*DW +: DW];
            do_wr = 1'b1;
`ifdef IO_SCAN_CHANGE_ONLY_EN
            do_wr = (v != last_model[j]);
`endif
            if (do_wr) begin
                exp_wr_q.push_back({AW'(4086 + j), v});
                last_model[j] = v;
            end
        end
        exp_out_q.push_back(outs);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus_a.IO_wEn) begin
                wr_cnt_a++;
                if (exp_wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL write: got %0h/%0h expected no write", bus_a.IO_addr, bus_a.IO_dataIn);
                end else begin
                    check("write", {bus_a.IO_addr, bus_a.IO_dataIn}, exp_wr_q.pop_front());
                end
            end
            if (done_a) begin
                if (exp_out_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scan_done: got pulse expected none");
                end else begin
                    check("out_regs", out_regs_a, exp_out_q.pop_front());
                end
            end
        end
    end

    task automatic cpu_write(input int addr, input logic [DW-1:0] data);
        cpu_we   = 1'b1;
        cpu_addr = AW'(addr);
        cpu_data = data;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic wait_done_a(input string name, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        if (!seen) fail(name);
    endtask

    task automatic measure_a();
        int first_busy, busy_n, done_n, done_cyc;
        logic [AW-1:0] first_addr;
        first_busy = -1; busy_n = 0; done_n = 0; done_cyc = -1; first_addr = '0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (busy_a) begin
                if (first_busy < 0) begin
                    first_busy = c;
                    first_addr = bus_a.IO_addr;
                end
                busy_n++;
            end
            if (done_a) begin
                done_n++;
                done_cyc = c;
            end
        end
        check("first_read_cycle", NS*DW'(first_busy), NS*DW'(20));
        check("first_read_addr", NS*DW'(first_addr), NS*DW'(4091));
        check("busy_cycles", NS*DW'(busy_n), NS*DW'(11));
        check("done_pulses", NS*DW'(done_n), NS*DW'(1));
        check("done_cycle", NS*DW'(done_cyc), NS*DW'(31));
        check("out_slot0", NS*DW'(out_regs_a[0 +: DW]), NS*DW'(32'hA0));
        check("out_slot4", NS*DW'(out_regs_a[4*DW +: DW]), NS*DW'(32'hA4));
        check("ram_4086", NS*DW'(ram_a[4086]), NS*DW'(32'h1234));
`ifdef IO_SCAN_CHANGE_ONLY_EN
        check("scan1_writes", NS*DW'(wr_cnt_a), NS*DW'(1));
`else
        check("scan1_writes", NS*DW'(wr_cnt_a), NS*DW'(5));
`endif
    endtask

    task automatic measure_b();
        logic busy_hist [41];
        int   ovr_n, first_ovr, done1, done2;
        ovr_n = 0; first_ovr = -1; done1 = -1; done2 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            busy_hist[c] = busy_b;
            if (ovr_b) begin
                ovr_n++;
                if (first_ovr < 0) first_ovr = c;
            end
            if (done_b) begin
                if (done1 < 0) done1 = c;
                else if (done2 < 0) done2 = c;
            end
        end
        check("b_first_read", NS*DW'(busy_hist[5]), NS*DW'(1));
        check("b_done1", NS*DW'(done1), NS*DW'(16));
        check("b_done2", NS*DW'(done2), NS*DW'(28));
        check("b_gap_idle", NS*DW'({busy_hist[15], busy_hist[16], busy_hist[17]}), NS*DW'(3'b101));
        check("b_gap_idle2", NS*DW'({busy_hist[27], busy_hist[28], busy_hist[29]}), NS*DW'(3'b101));
        check("b_first_overrun", NS*DW'(first_ovr), NS*DW'(15));
        check("b_overrun_count", NS*DW'(ovr_n), NS*DW'(4));
    endtask

    initial begin
        int wr_base;
        int idle_busy;
        bit hit;
        reset_n   = 1'b0;
        scan_en_a = 1'b0;
        scan_en_b = 1'b0;
        in_data_a = '0;
        in_data_b = '0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_data  = '0;
        for (int j = 0; j < NS; j++) last_model[j] = '0;
        repeat (2) @(negedge clk);

        check("rst_addr", NS*DW'(bus_a.IO_addr), '0);
        check("rst_wen", NS*DW'(bus_a.IO_wEn), '0);
        check("rst_din", NS*DW'(bus_a.IO_dataIn), '0);
        check("rst_out_regs", out_regs_a, '0);
        check("rst_flags", NS*DW'({busy_a, done_a, ovr_a, busy_b, done_b, ovr_b}), '0);

        for (int i = 0; i < NS; i++) begin
            cpu_write(4091 + i, 32'hA0 + i);
            out_exp[i*DW +: DW] = 32'hA0 + i;
        end
        in_data_a[0 +: DW] = 32'h1234;
        push_scan(in_data_a, out_exp);
        push_scan(in_data_a, out_exp);

        @(negedge clk);
        reset_n   = 1'b1;
        scan_en_a = 1'b1;
        scan_en_b = 1'b1;
        fork
            measure_a();
            measure_b();
        join

        wr_base = wr_cnt_a;
        wait_done_a("scan2_done", 40);
`ifdef IO_SCAN_CHANGE_ONLY_EN
        check("scan2_writes", NS*DW'(wr_cnt_a - wr_base), NS*DW'(0));
`else
        check("scan2_writes", NS*DW'(wr_cnt_a - wr_base), NS*DW'(5));
`endif

        // Drop scan_en during READ slot 1: scan must still finish, then stay quiet.
        push_scan(in_data_a, out_exp);
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (busy_a && !bus_a.IO_wEn && bus_a.IO_addr == AW'(4092)) hit = 1'b1;
        end
        if (!hit) fail("read_slot1_seen");
        scan_en_a = 1'b0;
        wait_done_a("scan3_done", 20);
        idle_busy = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy_a) idle_busy++;
        end
        check("no_scan_while_off", NS*DW'(idle_busy), NS*DW'(0));
        check("out_queue_drained", NS*DW'(exp_out_q.size()), NS*DW'(0));

        // Reset during WRITE slot 2: slots 2..4 keep their markers.
        cpu_write(4088, 32'hDEAD0002);
        cpu_write(4089, 32'hDEAD0003);
        cpu_write(4090, 32'hDEAD0004);
        in_data_a[2*DW +: DW] = 32'h22;
        in_data_a[3*DW +: DW] = 32'h33;
        in_data_a[4*DW +: DW] = 32'h44;
        push_scan(in_data_a, out_exp);
        scan_en_a = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clk);
            if (bus_a.IO_wEn && bus_a.IO_addr == AW'(4088)) hit = 1'b1;
        end
        if (!hit) fail("write_slot2_seen");
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_wen", NS*DW'(bus_a.IO_wEn), '0);
        check("rst_mid_busy", NS*DW'(busy_a), '0);
        exp_wr_q.delete();
        exp_out_q.delete();
        for (int j = 0; j < NS; j++) last_model[j] = '0;
        repeat (3) @(negedge clk);
        check("ram_4088_kept", NS*DW'(ram_a[4088]), NS*DW'(32'hDEAD0002));
        check("ram_4089_kept", NS*DW'(ram_a[4089]), NS*DW'(32'hDEAD0003));
        check("ram_4090_kept", NS*DW'(ram_a[4090]), NS*DW'(32'hDEAD0004));
        check("ram_4086_after", NS*DW'(ram_a[4086]), NS*DW'(32'h1234));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_scan_controller.md
# io_scan_controller

Sequencer that owns the IO port of the shared dual-port data RAM and periodically exchanges the memory-mapped IO window with the physical devices. Each scan reads the output slots (4091–4095, stepper control at 4095) into device-facing registers, then writes synchronized sensor values (phototransistors, beam break, spares) into the input slots (4086–4090). The CPU port is untouched; the CPU sees fresh inputs and has its output writes delivered once per scan.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDRESS_WIDTH, 12, RAM address width
- NUM_SLOTS, 5, slots per direction
- OUT_BASE, 4091, address of output slot 0
- IN_BASE, 4086, address of input slot 0
- SCAN_PERIOD, 1000, clk cycles between scan starts (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- scan_en  in  1  enables periodic scanning
- in_data  in  NUM_SLOTS*DATA_WIDTH  raw device inputs; slot j at [j*DATA_WIDTH +: DATA_WIDTH], asynchronous to clk
- IO_addr  out  ADDRESS_WIDTH  RAM IO port address
- IO_wEn  out  1  RAM IO port write enable
- IO_dataIn  out  DATA_WIDTH  RAM IO port write data
- IO_dataOut  in  DATA_WIDTH  RAM IO port read data (registered, valid the cycle after a non-write issue)
- out_regs  out  NUM_SLOTS*DATA_WIDTH  device-facing copies; slot i holds RAM[OUT_BASE+i]
- busy  out  1  high in READ, DRAIN, WRITE
- scan_done  out  1  one-cycle pulse at scan completion
- overrun  out  1  one-cycle pulse when a period expires with a scan already pending

## Operation
- Reset values: IO_addr=0, IO_wEn=0, IO_dataIn=0, out_regs=0, busy=0, scan_done=0, overrun=0, sync flops=0, last-written copies=0, pending=0, period counter=SCAN_PERIOD-1, state IDLE.
- Input synchronizer: two flops per in_data bit; snapshot taken from stage 2.
- Period counter: decrements each cycle while scan_en=1, holds while scan_en=0. At 0 with scan_en=1: reload SCAN_PERIOD-1, set pending. If pending already set, pulse overrun (request merged, not queued twice).
- FSM:
  - IDLE: IO_wEn=0. pending=1 → clear pending, enter READ, slot index 0.
  - READ (NUM_SLOTS cycles): IO_addr=OUT_BASE+i, IO_wEn=0. Each cycle i>0, capture IO_dataOut into out_regs slot i-1. After i=NUM_SLOTS-1 → DRAIN.
  - DRAIN (1 cycle): capture last out slot; snapshot all synchronized inputs; IO_wEn=0 → WRITE, index 0.
  - WRITE (NUM_SLOTS cycles, one per slot): IO_addr=IN_BASE+j, IO_dataIn=snap[j], IO_wEn=1 (qualified per Configuration); update last-written[j] when written. After j=NUM_SLOTS-1 → IDLE with scan_done=1.
- scan_en falling mid-scan: current scan completes; pending still honored.
- Address arithmetic: base+index truncated to ADDRESS_WIDTH; no overlap checking.
- Same-cycle CPU write to a slot being read: this scan gets the old value, next scan the new.

## Timing
- Period expiry at cycle T (idle FSM): READ T+1..T+NUM_SLOTS, DRAIN T+NUM_SLOTS+1, WRITE next NUM_SLOTS cycles, scan_done in the following IDLE cycle (T+12 at defaults). 11 busy cycles per scan at defaults.
- out_regs slot i updates on the edge ending cycle READ i+1 (or DRAIN for last slot); stable otherwise.
- Input-to-RAM latency: 2 sync cycles + wait to next DRAIN + write slot.
- Back-to-back scans: exactly one IDLE cycle (the scan_done cycle) between WRITE end and next READ.
- reset_n low: all outputs to reset values immediately (asynchronous), IO_wEn drops mid-cycle; remaining slots of the interrupted scan are not written.

## Configuration
- IO_SCAN_CHANGE_ONLY_EN defined: WRITE asserts IO_wEn for slot j only if snap[j] ≠ last-written[j]; unchanged slots still consume their cycle with IO_wEn=0. Scan timing unchanged.
- Undefined: IO_wEn=1 in every WRITE cycle; last-written copies not required.

## Test plan
- Reset: hold reset_n low → all outputs 0, IO_wEn 0; release, scan_en=1, SCAN_PERIOD=20 → first READ issues IO_addr=4091 at cycle 20, busy for 11 cycles, scan_done pulse once.
- Output fetch: preload RAM[4091..4095]=0xA0..0xA4 → after scan_done, out_regs slot 0=0xA0, slot 4 (stepper)=0xA4.
- Input write: in_data slot 0=0x1234, others 0 → RAM[4086]=0x1234 after scan; with IO_SCAN_CHANGE_ONLY_EN and no change, next scan has zero IO_wEn cycles; without it, five.
- Overrun: SCAN_PERIOD=5 → overrun pulses, scans back-to-back with exactly one IDLE cycle between.
- Reset mid-WRITE: assert reset_n at WRITE slot 2 → IO_wEn low immediately, RAM[4088..4090] unchanged.
- scan_en dropped during READ slot 1 → scan completes with scan_done; no further scans while low.
